// File: rtl/matmul_ctrl.sv
// Sequencer for an N x N matrix multiply: walks A/B BRAM read addresses in
// i/j/k order, accumulates one dot product at a time and writes it to the C BRAM.
module matmul_ctrl #(
    parameter int unsigned N               = 8,
    parameter int unsigned BRAM_ADDR_WIDTH = 6,
    parameter int unsigned BRAM_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [BRAM_ADDR_WIDTH-1:0] a_rd_addr_o,
    input  logic [BRAM_DATA_WIDTH-1:0] a_dout_i,
    output logic [BRAM_ADDR_WIDTH-1:0] b_rd_addr_o,
    input  logic [BRAM_DATA_WIDTH-1:0] b_dout_i,
    output logic [BRAM_ADDR_WIDTH-1:0] c_wr_addr_o,
    output logic                       c_wr_en_o,
    output logic [BRAM_DATA_WIDTH-1:0] c_din_o
);

    localparam int unsigned AW = BRAM_ADDR_WIDTH;
    localparam int unsigned DW = BRAM_DATA_WIDTH;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   i_q, i_d;
    logic [CW-1:0]   j_q, j_d;
    logic [CW-1:0]   k_q, k_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   a_addr_q, a_addr_d;
    logic [AW-1:0]   b_addr_q, b_addr_d;
    logic [AW-1:0]   c_addr_q, c_addr_d;
    logic [DW-1:0]   c_din_q, c_din_d;
    logic            c_wr_en_q, c_wr_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   prod_c;

    // Row-major linear address of element [r][c].
    function automatic logic [AW-1:0] lin_addr(input logic [CW-1:0] r,
                                               input logic [CW-1:0] c);
        return AW'(r) * AW'(N) + AW'(c);
    endfunction

    // Product wraps to DW bits, so signed and unsigned operands give the same pattern.
    assign prod_c = a_dout_i * b_dout_i;

    // Next-state, counters, accumulator and registered-output next values.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        a_addr_d  = a_addr_q;
        b_addr_d  = b_addr_q;
        c_addr_d  = c_addr_q;
        c_din_d   = c_din_q;
        c_wr_en_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                // Data returned now belongs to the address issued for k-1.
                if (k_q != '0) begin
                    acc_d = acc_q + prod_c;
                end
                if (k_q == LAST_IDX) begin
                    state_d = S_LAST;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            S_LAST: begin
                acc_d    = acc_q + prod_c;
                c_din_d  = acc_q + prod_c;
                c_addr_d = lin_addr(i_q, j_q);
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                acc_d = '0;
                k_d   = '0;
                if (j_q == LAST_IDX) begin
                    j_d = '0;
                    i_d = (i_q == LAST_IDX) ? '0 : i_q + CW'(1);
                end else begin
                    j_d = j_q + CW'(1);
                end
                state_d = ((i_q == LAST_IDX) && (j_q == LAST_IDX)) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read addresses follow the upcoming state so they are valid in that cycle.
        if (state_d == S_IDLE) begin
            a_addr_d = '0;
            b_addr_d = '0;
        end else if (state_d == S_MAC) begin
            a_addr_d = lin_addr(i_d, k_d);
            b_addr_d = lin_addr(k_d, j_d);
        end

        c_wr_en_d = (state_d == S_WRITE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            c_addr_q  <= '0;
            c_din_q   <= '0;
            c_wr_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
            c_addr_q  <= c_addr_d;
            c_din_q   <= c_din_d;
            c_wr_en_q <= c_wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign a_rd_addr_o = a_addr_q;
    assign b_rd_addr_o = b_addr_q;
    assign c_wr_addr_o = c_addr_q;
    assign c_wr_en_o   = c_wr_en_q;
    assign c_din_o     = c_din_q;

endmodule
